// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and writeback grant codes.
// Used by the writeback arbiter, RegisterFile and the hazard unit.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     data_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_BUF  = 2'd2
   } grant_e;

   function automatic logic is_real_reg(input reg_addr_t a);
      return a != REG_ZERO;
   endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle between WB, the long-latency unit, ID and the RegisterFile
// write port, as seen by the writeback arbiter.
interface rf_writeback_arbiter_if;
   import cpu_pkg::*;

   logic      wb_valid;
   reg_addr_t wb_addr;
   data_t     wb_data;
   logic      wb_ready;

   logic      lu_issue;
   reg_addr_t lu_issue_addr;
   logic      lu_req_valid;
   reg_addr_t lu_req_addr;
   data_t     lu_req_data;
   logic      lu_req_ready;

   reg_addr_t read_addr_1;
   reg_addr_t read_addr_2;
   logic      hazard_1;
   logic      hazard_2;

   logic      RegWrite;
   reg_addr_t write_addr;
   data_t     write_data;

   modport master (
      output wb_valid, wb_addr, wb_data,
      output lu_issue, lu_issue_addr,
      output lu_req_valid, lu_req_addr, lu_req_data,
      output read_addr_1, read_addr_2,
      input  wb_ready, lu_req_ready,
      input  hazard_1, hazard_2,
      input  RegWrite, write_addr, write_data
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data,
      input  lu_issue, lu_issue_addr,
      input  lu_req_valid, lu_req_addr, lu_req_data,
      input  read_addr_1, read_addr_2,
      output wb_ready, lu_req_ready,
      output hazard_1, hazard_2,
      output RegWrite, write_addr, write_data
   );

endinterface

// File: rtl/rf_pending_scoreboard.sv
// Tracks registers with an outstanding long-latency write so ID can
// stall their readers; a same-cycle set beats a clear.
module rf_pending_scoreboard
   import cpu_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      set_req,
   input  reg_addr_t set_addr,
   input  logic      clr_en,
   input  reg_addr_t clr_addr,
   input  reg_addr_t read_addr_1,
   input  reg_addr_t read_addr_2,
   output logic      hazard_1,
   output logic      hazard_2
);

   logic [31:1] pending;
   logic [31:1] set_mask;
   logic [31:1] clr_mask;
   logic [31:0] pend_full;
   logic        set_en;

   // Decode set/clear requests into per-register masks.
   always_comb begin
      set_en   = set_req && is_real_reg(set_addr);
      set_mask = '0;
      clr_mask = '0;
      for (int i = 1; i < 32; i++) begin
         set_mask[i] = set_en && (set_addr == 5'(i));
         clr_mask[i] = clr_en && (clr_addr == 5'(i));
      end
   end

   // Pending bits: clear on drain, set on issue, set has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
      end
   end

   // Hazard lookups; $0 maps onto a constant-zero bit.
   always_comb begin
      pend_full = {pending, 1'b0};
      hazard_1  = !reset && pend_full[read_addr_1];
      hazard_2  = !reset && pend_full[read_addr_2];
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the RegisterFile write port between WB and a buffered
// long-latency result, with an anti-starvation force for the buffer.
module rf_writeback_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
)(
   input  logic clk,
   input  logic reset,
   rf_writeback_arbiter_if.slave bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic      buf_valid;
   reg_addr_t buf_addr;
   data_t     buf_data;
   logic [3:0] starve_cnt;

   logic   wb_real;
   logic   force_drain;
   logic   lu_accept;
   logic   lu_ready;
   grant_e grant;

   // Pick the port owner: forced buffer, then WB, then idle buffer.
   always_comb begin
      wb_real     = bus.wb_valid && is_real_reg(bus.wb_addr);
      force_drain = buf_valid && (starve_cnt == LIMIT);
      grant       = GNT_NONE;
      if (!reset) begin
         if (force_drain) begin
            grant = GNT_BUF;
         end else if (wb_real) begin
            grant = GNT_WB;
         end else if (buf_valid) begin
            grant = GNT_BUF;
         end
      end
   end

   // Drive the RegisterFile port and the two handshakes.
   always_comb begin
      lu_ready         = !reset && !buf_valid;
      lu_accept        = bus.lu_req_valid && lu_ready;
      bus.lu_req_ready = lu_ready;
      bus.wb_ready     = reset || !force_drain;
      bus.RegWrite     = 1'b0;
      bus.write_addr   = REG_ZERO;
      bus.write_data   = '0;
      unique case (grant)
         GNT_WB: begin
            bus.RegWrite   = 1'b1;
            bus.write_addr = bus.wb_addr;
            bus.write_data = bus.wb_data;
         end
         GNT_BUF: begin
            bus.RegWrite   = 1'b1;
            bus.write_addr = buf_addr;
            bus.write_data = buf_data;
         end
         default: ;
      endcase
   end

   // Buffer occupancy and starvation counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid  <= 1'b0;
         starve_cnt <= 4'd0;
      end else if (grant == GNT_BUF) begin
         buf_valid  <= 1'b0;
         starve_cnt <= 4'd0;
      end else if (buf_valid) begin
         if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end else begin
         starve_cnt <= 4'd0;
         if (lu_accept && is_real_reg(bus.lu_req_addr)) begin
            buf_valid <= 1'b1;
         end
      end
   end

   // Capture the result payload whenever the buffer takes one.
   always_ff @(posedge clk) begin
      if (lu_accept) begin
         buf_addr <= bus.lu_req_addr;
         buf_data <= bus.lu_req_data;
      end
   end

   rf_pending_scoreboard u_sb (
      .clk         (clk),
      .reset       (reset),
      .set_req     (bus.lu_issue),
      .set_addr    (bus.lu_issue_addr),
      .clr_en      (grant == GNT_BUF),
      .clr_addr    (buf_addr),
      .read_addr_1 (bus.read_addr_1),
      .read_addr_2 (bus.read_addr_2),
      .hazard_1    (bus.hazard_1),
      .hazard_2    (bus.hazard_2)
   );

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model of the port.
module tb_rf_writeback_arbiter;

   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset;

   rf_writeback_arbiter_if bus ();

   rf_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: one parked result, how long it has waited,
   // the set of registers still owed a long-latency write
   bit        m_v;
   bit [4:0]  m_a;
   bit [31:0] m_d;
   int        m_wait;
   bit [31:0] m_pend;
   int        outq[$];

   bit held_wb;
   bit held_lu;

   bit        obs_we, obs_wbr, obs_lur, obs_h1;
   bit [4:0]  obs_addr;
   bit [31:0] obs_data;

   bit [31:0] rf [32];

   always @(posedge clk) begin
      if (bus.RegWrite) rf[bus.write_addr] <= bus.write_data;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      bit wb_real, forced, drain, e_we, e_wbr, e_lur, e_h1, e_h2;
      bit [4:0]  e_a;
      bit [31:0] e_d;
      wb_real = bus.wb_valid && bus.wb_addr != 0;
      forced  = m_v && m_wait >= LIMIT;
      drain   = !reset && m_v && (forced || !wb_real);
      e_we    = !reset && (drain || wb_real);
      e_a     = drain ? m_a : bus.wb_addr;
      e_d     = drain ? m_d : bus.wb_data;
      e_wbr   = reset || !forced;
      e_lur   = !reset && !m_v;
      e_h1    = !reset && bus.read_addr_1 != 0 && m_pend[bus.read_addr_1];
      e_h2    = !reset && bus.read_addr_2 != 0 && m_pend[bus.read_addr_2];
      @(negedge clk);
      chk("regwrite", bus.RegWrite, e_we);
      if (e_we) begin
         chk("waddr", bus.write_addr, e_a);
         chk("wdata", bus.write_data, e_d);
      end
      chk("wb_ready", bus.wb_ready, e_wbr);
      chk("lu_ready", bus.lu_req_ready, e_lur);
      chk("hazard_1", bus.hazard_1, e_h1);
      chk("hazard_2", bus.hazard_2, e_h2);
      obs_we   = bus.RegWrite;
      obs_addr = bus.write_addr;
      obs_data = bus.write_data;
      obs_wbr  = bus.wb_ready;
      obs_lur  = bus.lu_req_ready;
      obs_h1   = bus.hazard_1;
      held_wb  = !reset && bus.wb_valid && !e_wbr;
      held_lu  = !reset && bus.lu_req_valid && !e_lur;
      if (reset) begin
         m_v = 0; m_wait = 0; m_pend = 0;
         outq.delete();
      end else begin
         if (drain) begin
            m_v = 0; m_wait = 0; m_pend[m_a] = 0;
         end else if (m_v) begin
            m_wait++;
         end else if (bus.lu_req_valid && bus.lu_req_addr != 0) begin
            m_v = 1; m_wait = 0;
            m_a = bus.lu_req_addr;
            m_d = bus.lu_req_data;
            if (outq.size() > 0 && outq[0] == int'(m_a)) void'(outq.pop_front());
         end
         if (bus.lu_issue && bus.lu_issue_addr != 0) begin
            m_pend[bus.lu_issue_addr] = 1;
            outq.push_back(int'(bus.lu_issue_addr));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0;
      bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
      bus.lu_issue = 0; bus.lu_issue_addr = 0;
      bus.lu_req_valid = 0; bus.lu_req_addr = 0; bus.lu_req_data = 0;
      bus.read_addr_1 = 0; bus.read_addr_2 = 0;
   endtask

   task automatic set_wb(input bit v, input bit [4:0] a, input bit [31:0] d);
      bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
   endtask

   task automatic set_lu(input bit v, input bit [4:0] a, input bit [31:0] d);
      bus.lu_req_valid = v; bus.lu_req_addr = a; bus.lu_req_data = d;
   endtask

   task automatic issue(input bit v, input bit [4:0] a);
      bus.lu_issue = v; bus.lu_issue_addr = a;
   endtask

   task automatic rand_cycle();
      bit [4:0] a;
      bit ok;
      reset = ($urandom % 100) == 0;
      if (!held_wb) begin
         a = 0;
         for (int k = 0; k < 8; k++) begin
            a = 5'($urandom % 32);
            if (a == 0 || !m_pend[a]) break;
            a = 0;
         end
         set_wb(($urandom % 3) != 0, a, $urandom);
      end
      if (!held_lu) begin
         if (outq.size() > 0 && ($urandom % 2) == 1)
            set_lu(1, 5'(outq[0]), $urandom);
         else if (($urandom % 16) == 0)
            set_lu(1, 0, $urandom);
         else
            set_lu(0, 5'($urandom % 32), $urandom);
      end
      ok = 0;
      a  = 0;
      if (($urandom % 3) == 0) begin
         for (int k = 0; k < 8; k++) begin
            a = 5'(1 + $urandom % 31);
            if (!m_pend[a] && !(bus.wb_valid && bus.wb_addr == a)) begin
               ok = 1;
               break;
            end
         end
      end
      issue(ok, ok ? a : 5'd0);
      bus.read_addr_1 = 5'($urandom % 32);
      bus.read_addr_2 = 5'($urandom % 32);
      step();
   endtask

   initial begin
      m_v = 0; m_a = 0; m_d = 0; m_wait = 0; m_pend = 0;
      held_wb = 0; held_lu = 0;
      idle();
      #1;

      // reset with everything asserted
      reset = 1;
      set_wb(1, 5, 32'h1111_1111);
      issue(1, 7);
      set_lu(1, 7, 32'h2222_2222);
      bus.read_addr_1 = 7; bus.read_addr_2 = 5;
      step();
      chk("t1_we", obs_we, 0);
      chk("t1_lur", obs_lur, 0);
      chk("t1_h1", obs_h1, 0);
      idle();
      step();
      chk("t1_wbr", obs_wbr, 1);
      chk("t1_lur_rel", obs_lur, 1);

      // plain WB write
      set_wb(1, 5, 32'hDEAD_BEEF);
      step();
      chk("t2_we", obs_we, 1);
      chk("t2_addr", obs_addr, 5);
      chk("t2_data", obs_data, 32'hDEAD_BEEF);
      chk("t2_wbr", obs_wbr, 1);

      // long-latency result with WB idle
      idle();
      issue(1, 8);
      step();
      issue(0, 0);
      bus.read_addr_1 = 8;
      step();
      chk("t3_haz_set", obs_h1, 1);
      set_lu(1, 8, 32'h1234_5678);
      step();
      set_lu(0, 0, 0);
      step();
      chk("t3_we", obs_we, 1);
      chk("t3_addr", obs_addr, 8);
      chk("t3_data", obs_data, 32'h1234_5678);
      step();
      chk("t3_haz_clr", obs_h1, 0);
      chk("t3_rf", rf[8], 32'h1234_5678);

      // starvation: WB wins LIMIT times, then the buffer is forced
      idle();
      issue(1, 9);
      step();
      issue(0, 0);
      set_lu(1, 9, 32'hAAAA_5555);
      set_wb(1, 10, 32'h10);
      step();
      set_lu(0, 0, 0);
      for (int i = 0; i < LIMIT; i++) begin
         set_wb(1, 5'(11 + i), 32'(i));
         step();
         chk("t4_wb_win", obs_addr, 11 + i);
         chk("t4_wbr", obs_wbr, 1);
      end
      set_wb(1, 15, 32'h15);
      step();
      chk("t4_force_addr", obs_addr, 9);
      chk("t4_force_wbr", obs_wbr, 0);
      step();
      chk("t4_late_wb", obs_addr, 15);
      chk("t4_late_wbr", obs_wbr, 1);

      // $0 results and $0 WB writes
      idle();
      set_lu(1, 0, 32'hFFFF_0000);
      step();
      chk("t5_lur0", obs_lur, 1);
      set_lu(0, 0, 0);
      step();
      chk("t5_no_we", obs_we, 0);
      chk("t5_lur1", obs_lur, 1);
      issue(1, 3);
      step();
      issue(0, 0);
      set_lu(1, 3, 32'h0303_0303);
      set_wb(1, 20, 32'h20);
      step();
      set_lu(0, 0, 0);
      set_wb(1, 0, 32'h99);
      step();
      chk("t5_wb0_rdy", obs_wbr, 1);
      chk("t5_drain3", obs_addr, 3);

      // re-issue while draining the same register
      idle();
      issue(1, 4);
      step();
      issue(0, 0);
      set_lu(1, 4, 32'h0404_0404);
      set_wb(1, 21, 32'h21);
      step();
      set_lu(0, 0, 0);
      set_wb(0, 0, 0);
      issue(1, 4);
      bus.read_addr_1 = 4;
      step();
      issue(0, 0);
      step();
      chk("t6_set_wins", obs_h1, 1);

      // reset with a full buffer
      issue(1, 6);
      step();
      issue(0, 0);
      set_lu(1, 6, 32'h0606_0606);
      set_wb(1, 22, 32'h22);
      step();
      set_lu(0, 0, 0);
      set_wb(0, 0, 0);
      reset = 1;
      step();
      chk("t6_rst_we", obs_we, 0);
      reset = 0;
      bus.read_addr_1 = 6;
      step();
      chk("t6_discard", obs_we, 0);
      chk("t6_pend_clr", obs_h1, 0);

      // random traffic
      idle();
      reset = 1;
      step();
      held_wb = 0;
      held_lu = 0;
      for (int n = 0; n < 3000; n++) rand_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single register-file write port (RegWrite/write_addr/write_data) between two writers:
  - the in-order pipeline WB stage;
  - a long-latency unit (mult/div, later a cache refill).
- Holds one buffered long-latency result.
- Applies an anti-starvation counter that forces the buffered result through.
- Keeps a pending-destination scoreboard so ID can stall readers of registers the long-latency unit has not yet written.
- Sits between WB, the long-latency unit and RegisterFile.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a buffered result may wait before it is forced through. Legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- wb_valid  in  1  WB stage has a write.
- wb_addr  in  5  WB destination.
- wb_data  in  32  WB data.
- wb_ready  out  1  WB write accepted this cycle; when 0, the pipeline holds WB unchanged.
- lu_issue  in  1  long-latency op issued this cycle.
- lu_issue_addr  in  5  its destination register.
- lu_req_valid  in  1  long-latency result available.
- lu_req_addr  in  5  result destination.
- lu_req_data  in  32  result data.
- lu_req_ready  out  1  result accepted on this posedge when valid and ready are both 1.
- read_addr_1  in  5  ID source 1 (same signal that drives RegisterFile).
- read_addr_2  in  5  ID source 2.
- hazard_1  out  1  source 1 has a pending long-latency write.
- hazard_2  out  1  source 2 has a pending long-latency write.
- RegWrite  out  1  to RegisterFile.
- write_addr  out  5  to RegisterFile.
- write_data  out  32  to RegisterFile.

Behaviour:

State:
- buf_valid, buf_addr[4:0], buf_data[31:0]
- starve_cnt[3:0]
- pending[31:1]

Reset (while reset=1 at posedge):
- buf_valid=0, starve_cnt=0, pending all 0.
- Combinational outputs forced while reset=1: RegWrite=0, lu_req_ready=0, wb_ready=1, hazard_1=hazard_2=0.

Definitions (combinational):
- wb_real = wb_valid && wb_addr!=0
- force = buf_valid && starve_cnt==STARVE_LIMIT

Port grant (combinational, same cycle):
- force=1: buffer writes; wb_ready=0.
- Else if wb_real: WB writes; wb_ready=1.
- Else if buf_valid: buffer writes; wb_ready=1.
- Else: RegWrite=0; wb_ready=1.
- A WB write to $0 is accepted (wb_ready=1) but never drives RegWrite.

Buffer:
- lu_req_ready = !buf_valid. A buffered result therefore has a minimum 1-cycle latency to the RF.
- Accept with lu_req_addr!=0: load buffer, set buf_valid.
- Accept with lu_req_addr==0: the result is dropped and buf_valid stays 0.
- Buffer drain: buf_valid clears at the posedge where the buffer held the port.
- No same-cycle refill after a drain (ready was 0 that cycle).

Starvation counter:
- Increments each cycle buf_valid=1 and WB took the port.
- Clears to 0 when the buffer drains or when buf_valid=0.
- Never exceeds STARVE_LIMIT.

Scoreboard:
- lu_issue && lu_issue_addr!=0 sets pending[lu_issue_addr].
- A buffer drain clears pending[buf_addr].
- Set and clear of the same register in the same cycle: set wins.
- A WB write never changes pending.
- hazard_n = (read_addr_n!=0) && pending[read_addr_n], combinational.
- The register is readable from RegisterFile in the cycle after the drain posedge. hazard drops in that same cycle.

Rules the environment must honour (bench asserts them):
- No lu_issue to an already-pending register.
- No WB write to a pending register.
- wb_addr/wb_data are held stable while wb_ready=0.
- lu_req data is held stable while valid && !ready.

Reset mid-operation: buffered result and all pending bits are discarded.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0 (also usable by RegisterFile and hazard unit).
- Sub-module rf_pending_scoreboard: pending[31:1] set/clear logic plus the two hazard lookups.
- Top module: grant logic, buffer and counter.

Test Plan:
1. Reset with all inputs active → RegWrite=0, lu_req_ready=0, hazard_1=hazard_2=0. After release: wb_ready=1, lu_req_ready=1.
2. wb_valid=1, addr=5, data=0xDEADBEEF, no buffer → same cycle RegWrite=1, write_addr=5, write_data=0xDEADBEEF, wb_ready=1.
3. Issue $8 → hazard_1=1 (read_addr_1=8). lu_req $8=0x12345678 while WB idle → next cycle RF write of $8. The cycle after, hazard_1=0 and the RF reads 0x12345678.
4. Starvation, STARVE_LIMIT=4:
   - Buffered $9 with wb_valid held high on distinct registers.
   - WB wins 4 cycles; 5th cycle force: RegWrite writes $9, wb_ready=0, WB write lands the following cycle.
5. lu_req_addr=0 accepted → no RegWrite, lu_req_ready stays 1. wb_addr=0 → wb_ready=1, RegWrite=0, and a buffered $3 drains that same cycle.
6. Same cycle: lu_issue $4 and drain of buffered $4 → pending[4] stays 1. Reset asserted with buffer full → buffer never written, pending clear.
